// File: rtl/anim_frame_seq.sv
// Frame-index sequencer for the LED animation decoders: steps a 5-bit frame through a
// programmable range at a programmable rate, up/down, one-shot or looping, with pause/stop.
module anim_frame_seq #(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic             loop,
  input  logic [DIV_W-1:0] period,
  input  logic [4:0]       first,
  input  logic [4:0]       last,
  output logic [4:0]       frame,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [4:0]       frame_q, frame_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [4:0]       lo_q, lo_d;
  logic [4:0]       hi_q, hi_d;
  logic             dir_q, dir_d;
  logic             loop_q, loop_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic [4:0] new_lo, new_hi;
  logic       at_end, expire;

  assign new_lo = (first < last) ? first : last;
  assign new_hi = (first < last) ? last : first;
  assign at_end = dir_q ? (frame_q == lo_q) : (frame_q == hi_q);
  assign expire = (cnt_q == per_q - DIV_W'(1));

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dir_d   = dir_q;
    loop_d  = loop_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (stop) begin
      state_d = StIdle;
      frame_d = 5'd0;
      cnt_d   = '0;
    end else if (start) begin
      state_d = StRun;
      lo_d    = new_lo;
      hi_d    = new_hi;
      dir_d   = dir;
      loop_d  = loop;
      per_d   = (period == '0) ? DIV_W'(1) : period;
      frame_d = dir ? new_hi : new_lo;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          // Pause outranks expiry: the counter is frozen on the cycle HOLD is entered.
          if (pause) begin
            state_d = StHold;
          end else if (expire) begin
            cnt_d = '0;
            if (!at_end) begin
              frame_d = dir_q ? frame_q - 5'd1 : frame_q + 5'd1;
              tick_d  = 1'b1;
            end else if (loop_q) begin
              frame_d = dir_q ? hi_q : lo_q;
              tick_d  = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        StHold: begin
          if (!pause) state_d = StRun;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      frame_q <= 5'd0;
      cnt_q   <= '0;
      per_q   <= '0;
      lo_q    <= 5'd0;
      hi_q    <= 5'd0;
      dir_q   <= 1'b0;
      loop_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dir_q   <= dir_d;
      loop_q  <= loop_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign frame = frame_q;
  assign busy  = (state_q != StIdle);
  assign tick  = tick_q;
  assign done  = done_q;

endmodule

// File: tb/tb_anim_frame_seq.sv
// Directed bench for anim_frame_seq: a cycle-by-cycle vector table followed by
// hand-written multi-cycle sequences (one-shot, looping, pause, full range, reset).
module tb_anim_frame_seq;

  localparam int unsigned DIV_W = 24;

  logic             clk;
  logic             rst_n, start, stop, pause, dir, loop;
  logic [DIV_W-1:0] period;
  logic [4:0]       first, last;
  logic [4:0]       frame;
  logic             busy, tick, done;

  int n_cmp  = 0;
  int n_fail = 0;

  anim_frame_seq #(.DIV_W(DIV_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .pause  (pause),
    .dir    (dir),
    .loop   (loop),
    .period (period),
    .first  (first),
    .last   (last),
    .frame  (frame),
    .busy   (busy),
    .tick   (tick),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, start, stop, pause, dir, loop;
    logic [23:0] period;
    logic [4:0]  first, last;
    logic [4:0]  e_frame;
    logic        e_busy, e_tick, e_done;
  } vec_t;

  vec_t vecs[29];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int ef, input int eb, input int et,
                         input int ed);
    chk({name, ".frame"}, int'(frame), ef);
    chk({name, ".busy"}, int'(busy), eb);
    chk({name, ".tick"}, int'(tick), et);
    chk({name, ".done"}, int'(done), ed);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic kick(input logic d, input logic l, input int p, input int f, input int la);
    idle_in();
    start = 1'b1; dir = d; loop = l; period = DIV_W'(p); first = 5'(f); last = 5'(la);
    step();
    start = 1'b0;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic sp, input logic pa,
                              input logic d, input logic l, input int p, input int f,
                              input int la, input int ef, input logic eb, input logic et,
                              input logic ed);
    vec_t v;
    v.rst_n = r; v.start = s; v.stop = sp; v.pause = pa; v.dir = d; v.loop = l;
    v.period = 24'(p); v.first = 5'(f); v.last = 5'(la);
    v.e_frame = 5'(ef); v.e_busy = eb; v.e_tick = et; v.e_done = ed;
    return v;
  endfunction

  initial begin
    int ticks;
    int ef;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    dir = 1'b0; loop = 1'b0; period = '0; first = '0; last = '0;

    //            rst st sp pa d  l  per f   l   | frame busy tick done
    vecs[0]  = mk(0, 1, 0, 0, 0, 0, 3, 5,  7,    0,  0, 0, 0);  // reset beats start
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 3, 5,  7,    0,  0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 3, 20, 20,   20, 1, 0, 0);  // single-frame one-shot
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 3, 20, 20,   20, 1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 3, 20, 20,   20, 1, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 3, 20, 20,   20, 0, 0, 1);  // done at N+3
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 3, 20, 20,   20, 0, 0, 0);
    vecs[7]  = mk(1, 0, 1, 0, 0, 0, 3, 20, 20,   0,  0, 0, 0);  // stop in idle clears frame
    vecs[8]  = mk(1, 1, 1, 0, 0, 0, 3, 10, 12,   0,  0, 0, 0);  // stop beats start
    vecs[9]  = mk(1, 1, 0, 0, 0, 0, 0, 2,  4,    2,  1, 0, 0);  // period 0 acts as 1
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 2,  4,    3,  1, 1, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 2,  4,    4,  1, 1, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 2,  4,    4,  0, 0, 1);
    vecs[13] = mk(1, 1, 0, 0, 1, 1, 1, 4,  2,    4,  1, 0, 0);  // down, swapped, loop
    vecs[14] = mk(1, 0, 0, 0, 1, 1, 1, 4,  2,    3,  1, 1, 0);
    vecs[15] = mk(1, 0, 0, 0, 1, 1, 1, 4,  2,    2,  1, 1, 0);
    vecs[16] = mk(1, 0, 0, 0, 1, 1, 1, 4,  2,    4,  1, 1, 0);  // wrap lo -> hi
    vecs[17] = mk(1, 1, 0, 0, 0, 0, 2, 8,  9,    8,  1, 0, 0);  // restart while busy
    vecs[18] = mk(1, 0, 0, 0, 0, 0, 2, 8,  9,    8,  1, 0, 0);
    vecs[19] = mk(1, 0, 0, 0, 0, 0, 2, 8,  9,    9,  1, 1, 0);
    vecs[20] = mk(1, 0, 0, 1, 0, 0, 2, 8,  9,    9,  1, 0, 0);  // enter hold
    vecs[21] = mk(1, 0, 0, 1, 0, 0, 2, 8,  9,    9,  1, 0, 0);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, 2, 8,  9,    9,  1, 0, 0);  // back to run, cnt frozen
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 2, 8,  9,    9,  1, 0, 0);
    vecs[24] = mk(1, 0, 0, 0, 0, 0, 2, 8,  9,    9,  0, 0, 1);
    vecs[25] = mk(1, 1, 0, 1, 0, 0, 1, 1,  3,    1,  1, 0, 0);  // start beats pause
    vecs[26] = mk(1, 0, 0, 1, 0, 0, 1, 1,  3,    1,  1, 0, 0);  // then hold
    vecs[27] = mk(1, 0, 0, 0, 0, 0, 1, 1,  3,    1,  1, 0, 0);
    vecs[28] = mk(1, 0, 1, 0, 0, 0, 1, 1,  3,    0,  0, 0, 0);  // stop from run

    for (int i = 0; i < 29; i++) begin
      rst_n = vecs[i].rst_n; start = vecs[i].start; stop = vecs[i].stop;
      pause = vecs[i].pause; dir = vecs[i].dir; loop = vecs[i].loop;
      period = vecs[i].period; first = vecs[i].first; last = vecs[i].last;
      step();
      chk($sformatf("vec%0d", i), int'(vecs[i].e_frame), int'(frame));
      n_cmp--;  // re-check below in canonical (actual, expected) order
      if (frame !== vecs[i].e_frame) n_fail--;
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_frame), int'(vecs[i].e_busy),
              int'(vecs[i].e_tick), int'(vecs[i].e_done));
    end

    // One-shot up 6..13, period 4: done and busy fall at N+32.
    kick(1'b0, 1'b0, 4, 6, 13);
    chk_all("oneshot.start", 6, 1, 0, 0);
    ticks = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (tick) ticks++;
      ef = (i < 32) ? 6 + i / 4 : 13;
      chk_all($sformatf("oneshot.c%0d", i), ef, (i < 32) ? 1 : 0,
              (i % 4 == 0 && i < 32) ? 1 : 0, (i == 32) ? 1 : 0);
    end
    chk("oneshot.ticks", ticks, 7);

    // Looping down with swapped bounds 9..3, period 2; never done; then stop.
    kick(1'b1, 1'b1, 2, 9, 3);
    chk_all("loopdn.start", 9, 1, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      step();
      chk_all($sformatf("loopdn.c%0d", i), 9 - ((i / 2) % 7), 1, (i % 2 == 0) ? 1 : 0, 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("loopdn.stop", 0, 0, 0, 0);

    // Pause at counter=2 of a period-5 frame for 7 cycles.
    kick(1'b0, 1'b0, 5, 0, 5);
    step();
    step();
    chk_all("pause.pre", 0, 1, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_all($sformatf("pause.hold%0d", i), 0, 1, 0, 0);
    end
    pause = 1'b0;
    step();
    chk_all("pause.resume", 0, 1, 0, 0);
    step();
    step();
    chk_all("pause.run2", 0, 1, 0, 0);
    step();
    chk_all("pause.advance", 1, 1, 1, 0);

    // Full range 0..31 looping up: 31 wraps to 0 with a tick.
    kick(1'b0, 1'b1, 1, 0, 31);
    chk_all("full.start", 0, 1, 0, 0);
    for (int i = 1; i <= 31; i++) step();
    chk_all("full.top", 31, 1, 1, 0);
    step();
    chk_all("full.wrap", 0, 1, 1, 0);

    // Reset mid-sequence.
    rst_n = 1'b0;
    step();
    chk_all("midreset", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_all("midreset.after", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
